// File: rtl/syscall_unit.sv
// Console/exit syscall engine: prints signed integers, characters and NUL-terminated
// strings over a ready/valid console port, stalling the pipeline while it works.
module syscall_unit #(
    parameter int MAX_STR_LEN = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        syscall_valid,
    input  logic [31:0] v0,
    input  logic [31:0] a0,
    output logic        mem_rd_en,
    output logic [31:0] mem_addr,
    input  logic [7:0]  mem_rdata,
    output logic        out_valid,
    output logic [7:0]  out_data,
    input  logic        out_ready,
    output logic        busy,
    output logic        halt,
    output logic        err_code
);

    localparam int CW = $clog2(MAX_STR_LEN + 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INT_SIGN  = 3'd1,
        INT_DIGIT = 3'd2,
        CHAR_EMIT = 3'd3,
        STR_REQ   = 3'd4,
        STR_WAIT  = 3'd5,
        HALTED    = 3'd6
    } state_t;

    state_t        state_r, state_nxt;
    logic          out_valid_r, out_valid_nxt;
    logic [7:0]    out_data_r, out_data_nxt;
    logic [31:0]   mag_r, mag_nxt;
    logic [3:0]    idx_r, idx_nxt;
    logic [3:0]    digit_r, digit_nxt;
    logic          started_r, started_nxt;
    logic          last_r, last_nxt;
    logic [31:0]   addr_r, addr_nxt;
    logic [CW-1:0] cnt_r, cnt_nxt;
    logic          rd_pend_r, rd_pend_nxt;
    logic          err_r, err_nxt;
    logic          xfer_s;
    logic          supported_s;
    logic [31:0]   pow_s;

    function automatic logic [31:0] pow10(input logic [3:0] idx);
        case (idx)
            4'd0:    pow10 = 32'd1;
            4'd1:    pow10 = 32'd10;
            4'd2:    pow10 = 32'd100;
            4'd3:    pow10 = 32'd1000;
            4'd4:    pow10 = 32'd10000;
            4'd5:    pow10 = 32'd100000;
            4'd6:    pow10 = 32'd1000000;
            4'd7:    pow10 = 32'd10000000;
            4'd8:    pow10 = 32'd100000000;
            4'd9:    pow10 = 32'd1000000000;
            default: pow10 = 32'd1;
        endcase
    endfunction

    assign xfer_s      = out_valid_r & out_ready;
    assign pow_s       = pow10(idx_r);
    assign supported_s = (v0 == 32'd1) || (v0 == 32'd4) || (v0 == 32'd11);

    assign busy      = ((state_r != IDLE) && (state_r != HALTED)) ||
                       (syscall_valid && (state_r == IDLE) && supported_s);
    assign halt      = (state_r == HALTED);
    assign mem_rd_en = (state_r == STR_REQ);
    assign mem_addr  = mem_rd_en ? addr_r : 32'd0;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign err_code  = err_r;

    // Next-state and datapath update; a pending character drops only when transferred.
    always_comb begin
        state_nxt     = state_r;
        out_valid_nxt = out_valid_r & ~out_ready;
        out_data_nxt  = out_data_r;
        mag_nxt       = mag_r;
        idx_nxt       = idx_r;
        digit_nxt     = digit_r;
        started_nxt   = started_r;
        last_nxt      = last_r;
        addr_nxt      = addr_r;
        cnt_nxt       = cnt_r;
        rd_pend_nxt   = rd_pend_r;
        err_nxt       = 1'b0;
        case (state_r)
            IDLE: begin
                if (syscall_valid) begin
                    case (v0)
                        32'd1: begin
                            state_nxt     = INT_SIGN;
                            mag_nxt       = a0[31] ? (~a0 + 32'd1) : a0;
                            out_valid_nxt = a0[31];
                            out_data_nxt  = 8'h2D;
                            idx_nxt       = 4'd9;
                            digit_nxt     = 4'd0;
                            started_nxt   = 1'b0;
                            last_nxt      = 1'b0;
                        end
                        32'd4: begin
                            state_nxt = STR_REQ;
                            addr_nxt  = a0;
                            cnt_nxt   = '0;
                        end
                        32'd11: begin
                            state_nxt     = CHAR_EMIT;
                            out_valid_nxt = 1'b1;
                            out_data_nxt  = a0[7:0];
                        end
                        32'd10:  state_nxt = HALTED;
                        default: err_nxt   = 1'b1;
                    endcase
                end else begin
                    state_nxt = IDLE;
                end
            end
            INT_SIGN: begin
                if (!out_valid_r || xfer_s) begin
                    state_nxt = INT_DIGIT;
                end else begin
                    state_nxt = INT_SIGN;
                end
            end
            INT_DIGIT: begin
                if (out_valid_r) begin
                    if (xfer_s && last_r) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = INT_DIGIT;
                    end
                end else if (mag_r >= pow_s) begin
                    mag_nxt   = mag_r - pow_s;
                    digit_nxt = digit_r + 4'd1;
                end else begin
                    // Digit complete; the units digit is always printed so zero yields "0".
                    if ((digit_r != 4'd0) || started_r || (idx_r == 4'd0)) begin
                        out_valid_nxt = 1'b1;
                        out_data_nxt  = 8'h30 + {4'h0, digit_r};
                        started_nxt   = 1'b1;
                    end else begin
                        started_nxt = started_r;
                    end
                    digit_nxt = 4'd0;
                    if (idx_r == 4'd0) begin
                        last_nxt = 1'b1;
                    end else begin
                        idx_nxt = idx_r - 4'd1;
                    end
                end
            end
            CHAR_EMIT: begin
                if (xfer_s) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt = CHAR_EMIT;
                end
            end
            STR_REQ: begin
                state_nxt   = STR_WAIT;
                rd_pend_nxt = 1'b1;
            end
            STR_WAIT: begin
                if (rd_pend_r) begin
                    rd_pend_nxt = 1'b0;
                    if (mem_rdata == 8'h00) begin
                        state_nxt = IDLE;
                    end else begin
                        out_valid_nxt = 1'b1;
                        out_data_nxt  = mem_rdata;
                        cnt_nxt       = cnt_r + {{(CW-1){1'b0}}, 1'b1};
                        addr_nxt      = addr_r + 32'd1;
                    end
                end else if (xfer_s) begin
                    if (cnt_r == CW'(MAX_STR_LEN)) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = STR_REQ;
                    end
                end else begin
                    state_nxt = STR_WAIT;
                end
            end
            HALTED:  state_nxt = HALTED;
            default: state_nxt = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
            out_data_r  <= 8'h00;
            mag_r       <= 32'd0;
            idx_r       <= 4'd0;
            digit_r     <= 4'd0;
            started_r   <= 1'b0;
            last_r      <= 1'b0;
            addr_r      <= 32'd0;
            cnt_r       <= '0;
            rd_pend_r   <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            state_r     <= state_nxt;
            out_valid_r <= out_valid_nxt;
            out_data_r  <= out_data_nxt;
            mag_r       <= mag_nxt;
            idx_r       <= idx_nxt;
            digit_r     <= digit_nxt;
            started_r   <= started_nxt;
            last_r      <= last_nxt;
            addr_r      <= addr_nxt;
            cnt_r       <= cnt_nxt;
            rd_pend_r   <= rd_pend_nxt;
            err_r       <= err_nxt;
        end
    end

endmodule

// File: doc/syscall_unit.md
SYSCALL_UNIT -- requirements
Module: syscall_unit

Interface
REQ-001 Parameter: MAX_STR_LEN, 256, maximum characters emitted per print_string before forced termination.
REQ-002 clk  input  1  pipeline clock, all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 syscall_valid  input  1  one-cycle pulse from the writeback stage: syscall retiring.
REQ-005 v0  input  32  syscall code, sampled with syscall_valid.
REQ-006 a0  input  32  argument, sampled with syscall_valid.
REQ-007 mem_rd_en  output  1  byte read request to data memory.
REQ-008 mem_addr  output  32  byte address of the read.
REQ-009 mem_rdata  input  8  read byte, valid exactly one cycle after mem_rd_en.
REQ-010 out_valid  output  1  console character available.
REQ-011 out_data  output  8  ASCII character.
REQ-012 out_ready  input  1  console accepts character.
REQ-013 busy  output  1  stall request to the hazard unit (freeze fetch/decode).
REQ-014 halt  output  1  sticky, program exited.
REQ-015 err_code  output  1  one-cycle pulse, unsupported syscall code.

Function
REQ-016 States SHALL be IDLE, INT_SIGN, INT_DIGIT, CHAR_EMIT, STR_REQ, STR_WAIT, HALTED.
REQ-017 In IDLE, syscall_valid SHALL latch v0/a0 and dispatch next cycle: 1 -> print_int, 4 -> print_string, 11 -> print_char, 10 -> HALTED, other -> err_code=1 next cycle, stay IDLE.
REQ-018 busy SHALL equal (state != IDLE && state != HALTED) OR (syscall_valid AND state==IDLE AND v0 in {1,4,11}); combinational.
REQ-019 syscall_valid outside IDLE SHALL be ignored (no latch, no err_code).
REQ-020 Transfer SHALL occur on out_valid AND out_ready; out_data SHALL hold stable while out_valid AND NOT out_ready.
REQ-021 print_char: emit a0[7:0] once, return to IDLE the cycle after transfer.
REQ-022 print_int: a0 signed; if negative emit '-' (0x2D) first, then magnitude as unsigned 32-bit (-2147483648 -> 2147483648).
REQ-023 Digits SHALL be produced by repeated subtraction of powers of ten 10^9..10^0, at most one subtraction per cycle, most significant first.
REQ-024 Leading zeros SHALL be suppressed; value 0 SHALL emit exactly "0"; no trailing newline.
REQ-025 print_string: read bytes at a0, a0+1, ... (32-bit modulo wrap); one outstanding read; next read issued only after previous byte transferred.
REQ-026 Byte 0x00 SHALL terminate without emission; after MAX_STR_LEN emitted characters, terminate without further reads.
REQ-027 mem_rd_en SHALL be 1 only in STR_REQ for one cycle; mem_addr SHALL be 0 when mem_rd_en is 0.
REQ-028 HALTED: halt=1, busy=0, all syscall_valid ignored until reset.
REQ-029 Return to IDLE SHALL occur the cycle after final transfer; a back-to-back syscall_valid that cycle is accepted.

Reset
REQ-030 reset SHALL force IDLE and, next cycle, out_valid=0, out_data=0, mem_rd_en=0, mem_addr=0, busy=0, halt=0, err_code=0, internal counters/latches 0.
REQ-031 reset mid-operation SHALL abort immediately; no further characters or reads; partial output not completed.
REQ-032 reset SHALL take priority over syscall_valid in the same cycle.

Verification
REQ-033 v0=1, a0=0xFFFFFF85, out_ready=1 -> "-123" (0x2D,0x31,0x32,0x33), busy low afterwards.
REQ-034 v0=1, a0=0 and a0=0x80000000 -> "0" and "-2147483648" respectively.
REQ-035 v0=4, a0=0x100, memory "Hi\0" at 0x100, out_ready toggling 1/0 -> reads 0x100,0x101,0x102 only, output "Hi", out_data stable while stalled.
REQ-036 v0=4, MAX_STR_LEN=4, 10 non-zero bytes, a0=0xFFFFFFFE -> exactly 4 chars, addresses wrap 0xFFFFFFFE,0xFFFFFFFF,0x0,0x1.
REQ-037 v0=7 -> err_code single pulse, no output, busy 0; then v0=10 -> halt=1 sticky, subsequent v0=11 ignored.
REQ-038 reset asserted during third digit of print_int 98765 -> outputs return to reset values next cycle, no further characters.
